tcam_lookup_stage: RTL and testbench

Parametrised match-action lookup stage for the per-stage packet pipeline. It sits between the key extractor and the action engine. It holds a DEPTH-entry ternary match table and an action RAM, both written over a control channel, and looks up one key per cycle with a fixed 3-cycle latency. Unlike the previous engine it supports valid/ready backpressure, an on-miss default action, per-entry valid bits and hit/miss statistics counters.

---
 rtl/lookup_pkg.sv | 13 +
 rtl/tcam_lookup_stage_match.sv | 72 +++++++
 rtl/tcam_lookup_stage.sv | 137 +++++++++++++
 tb/tb_tcam_lookup_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lookup_pkg.sv
// Shared constants for the match-action lookup stage: action word geometry,
// the miss action, and the positions of the per-stage valid bits.
package lookup_pkg;

    localparam int ACT_LEN = 25;
    localparam logic [ACT_LEN-1:0] DEFAULT_ACTION = 25'h3f;

    localparam int S1 = 0;
    localparam int S2 = 1;
    localparam int S3 = 2;
    localparam int NUM_STAGES = 3;

endpackage

// File: rtl/tcam_lookup_stage_match.sv
// Ternary match table: entry key/mask storage, per-entry valid bits, parallel
// compare and lowest-index priority encoder with a registered hit/index result.
module tcam_match_array #(
    parameter int KEY_LEN = 896,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic               en,
    input  logic [KEY_LEN-1:0] lookup_key,
    input  logic               cfg_wr_en,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [KEY_LEN-1:0] cfg_key,
    input  logic [KEY_LEN-1:0] cfg_mask,
    input  logic               cfg_entry_valid,
    output logic               hit,
    output logic [AW-1:0]      hit_addr
);

    logic [KEY_LEN-1:0] key_mem  [DEPTH];
    logic [KEY_LEN-1:0] mask_mem [DEPTH];
    logic [DEPTH-1:0]   entry_vld;
    logic [DEPTH-1:0]   match_vec;
    logic               match_any;
    logic [AW-1:0]      match_idx;

    always_ff @(posedge axis_clk) begin
        if (cfg_wr_en) begin
            key_mem[cfg_addr]  <= cfg_key;
            mask_mem[cfg_addr] <= cfg_mask;
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            entry_vld <= '0;
        end else if (cfg_wr_en) begin
            entry_vld[cfg_addr] <= cfg_entry_valid;
        end
    end

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = entry_vld[i] && ~|((lookup_key ^ key_mem[i]) & mask_mem[i]);
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_any = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            hit      <= 1'b0;
            hit_addr <= '0;
        end else if (en) begin
            hit      <= match_any;
            hit_addr <= match_idx;
        end
    end

endmodule

// File: rtl/tcam_lookup_stage.sv
// Three-stage match-action lookup: key capture, ternary compare, action read,
// with valid/ready backpressure, default action on miss and hit/miss counters.
module tcam_lookup_stage #(
    parameter int KEY_LEN = 896,
    parameter int PHV_LEN = 1124,
    parameter int ACT_LEN = lookup_pkg::ACT_LEN,
    parameter int DEPTH   = 16,
    parameter logic [ACT_LEN-1:0] DEFAULT_ACTION = lookup_pkg::DEFAULT_ACTION,
    parameter int STAGE   = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic [KEY_LEN-1:0] extract_key,
    input  logic [PHV_LEN-1:0] pkt_hdr_vec,
    input  logic               key_valid,
    output logic               key_ready,
    output logic [ACT_LEN-1:0] action,
    output logic [PHV_LEN-1:0] pkt_hdr_vec_out,
    output logic               hit,
    output logic [AW-1:0]      hit_addr,
    output logic               action_valid,
    input  logic               action_ready,
    input  logic               cfg_wr_en,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [KEY_LEN-1:0] cfg_key,
    input  logic [KEY_LEN-1:0] cfg_mask,
    input  logic               cfg_entry_valid,
    input  logic               act_wr_en,
    input  logic [AW-1:0]      act_addr,
    input  logic [ACT_LEN-1:0] act_data,
    input  logic               stat_clr,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    import lookup_pkg::*;

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || STAGE < 0) begin : g_cfg_check
        $error("tcam_lookup_stage: DEPTH must be a power of two in 2..64 and STAGE >= 0");
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic                  en;
    logic                  handshake;
    logic [NUM_STAGES-1:0] stage_vld;
    logic [KEY_LEN-1:0]    key_p0;
    logic [PHV_LEN-1:0]    phv_p0;
    logic [PHV_LEN-1:0]    phv_p1;
    logic                  hit_p1;
    logic [AW-1:0]         addr_p1;
    logic [ACT_LEN-1:0]    act_ram [DEPTH];

    assign en           = ~action_valid | action_ready;
    assign key_ready    = en;
    assign action_valid = stage_vld[S3];
    assign handshake    = action_valid & action_ready;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            stage_vld <= '0;
        end else if (en) begin
            stage_vld[S1] <= key_valid;
            stage_vld[S2] <= stage_vld[S1];
            stage_vld[S3] <= stage_vld[S2];
        end
    end

    // ---- S1: capture key and PHV on accept ----
    always_ff @(posedge axis_clk) begin
        if (en && key_valid) begin
            key_p0 <= extract_key;
            phv_p0 <= pkt_hdr_vec;
        end
    end

    // ---- S2: ternary compare, PHV follows ----
    tcam_match_array #(
        .KEY_LEN (KEY_LEN),
        .DEPTH   (DEPTH)
    ) u_match (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .en              (en),
        .lookup_key      (key_p0),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_addr        (cfg_addr),
        .cfg_key         (cfg_key),
        .cfg_mask        (cfg_mask),
        .cfg_entry_valid (cfg_entry_valid),
        .hit             (hit_p1),
        .hit_addr        (addr_p1)
    );

    always_ff @(posedge axis_clk) begin
        if (en) begin
            phv_p1 <= phv_p0;
        end
    end

    // ---- S3: registered action read into the output register ----
    always_ff @(posedge axis_clk) begin
        if (act_wr_en) begin
            act_ram[act_addr] <= act_data;
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            action          <= '0;
            hit             <= 1'b0;
            hit_addr        <= '0;
            pkt_hdr_vec_out <= '0;
        end else if (en) begin
            action          <= hit_p1 ? act_ram[addr_p1] : DEFAULT_ACTION;
            hit             <= hit_p1;
            hit_addr        <= hit_p1 ? addr_p1 : '0;
            pkt_hdr_vec_out <= phv_p1;
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stat_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (handshake) begin
            if (hit) hit_cnt  <= sat_inc(hit_cnt);
            else     miss_cnt <= sat_inc(miss_cnt);
        end
    end

endmodule

// File: tb/tb_tcam_lookup_stage.sv
// Directed bench for tcam_lookup_stage: miss path, hits, priority, backpressure,
// entry-write timing, counter saturation/clear and mid-operation reset.
module tb_tcam_lookup_stage;

    localparam int KEY_LEN = 896;
    localparam int PHV_LEN = 1124;
    localparam int ACT_LEN = 25;
    localparam int AW      = 4;

    logic               axis_clk = 1'b0;
    logic               aresetn;
    logic [KEY_LEN-1:0] extract_key;
    logic [PHV_LEN-1:0] pkt_hdr_vec;
    logic               key_valid;
    logic               key_ready;
    logic [ACT_LEN-1:0] action;
    logic [PHV_LEN-1:0] pkt_hdr_vec_out;
    logic               hit;
    logic [AW-1:0]      hit_addr;
    logic               action_valid;
    logic               action_ready;
    logic               cfg_wr_en;
    logic [AW-1:0]      cfg_addr;
    logic [KEY_LEN-1:0] cfg_key;
    logic [KEY_LEN-1:0] cfg_mask;
    logic               cfg_entry_valid;
    logic               act_wr_en;
    logic [AW-1:0]      act_addr;
    logic [ACT_LEN-1:0] act_data;
    logic               stat_clr;
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
    logic [KEY_LEN-1:0] key_a;
    logic [KEY_LEN-1:0] key_b;
    logic [KEY_LEN-1:0] ones;
    int sent;
    int recv;

    always #5 axis_clk = ~axis_clk;

    tcam_lookup_stage dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .extract_key     (extract_key),
        .pkt_hdr_vec     (pkt_hdr_vec),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .action          (action),
        .pkt_hdr_vec_out (pkt_hdr_vec_out),
        .hit             (hit),
        .hit_addr        (hit_addr),
        .action_valid    (action_valid),
        .action_ready    (action_ready),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_addr        (cfg_addr),
        .cfg_key         (cfg_key),
        .cfg_mask        (cfg_mask),
        .cfg_entry_valid (cfg_entry_valid),
        .act_wr_en       (act_wr_en),
        .act_addr        (act_addr),
        .act_data        (act_data),
        .stat_clr        (stat_clr),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic cfg_entry(input logic [AW-1:0] a, input logic [KEY_LEN-1:0] k,
                             input logic [KEY_LEN-1:0] m, input logic v);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_key = k; cfg_mask = m; cfg_entry_valid = v;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic act_write(input logic [AW-1:0] a, input logic [ACT_LEN-1:0] d);
        act_wr_en = 1'b1; act_addr = a; act_data = d;
        tick();
        act_wr_en = 1'b0;
    endtask

    task automatic sat_bump(input logic is_hit);
        if (is_hit) begin
            if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
        end else begin
            if (exp_misses != 32'hFFFF_FFFF) exp_misses++;
        end
    endtask

    // One isolated lookup: accept in cycle T, check outputs in T+3, handshake at end of T+3.
    task automatic lookup_check(input string tag, input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p,
                                input logic ehit, input logic [AW-1:0] eaddr, input logic [ACT_LEN-1:0] eact);
        extract_key = k; pkt_hdr_vec = p; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        tick();
        chk({tag, ".valid"}, action_valid, 1'b1);
        chk({tag, ".hit"}, hit, ehit);
        chk({tag, ".addr"}, hit_addr, eaddr);
        chk({tag, ".action"}, action, eact);
        chk({tag, ".phv"}, pkt_hdr_vec_out, p);
        tick();
        sat_bump(ehit);
    endtask

    initial begin
        key_a = {28{32'hA5A5_0001}};
        key_b = {28{32'h5A5A_0002}};
        ones  = '1;
        aresetn = 1'b0; extract_key = '0; pkt_hdr_vec = '0; key_valid = 1'b0; action_ready = 1'b1;
        cfg_wr_en = 1'b0; cfg_addr = '0; cfg_key = '0; cfg_mask = '0; cfg_entry_valid = 1'b0;
        act_wr_en = 1'b0; act_addr = '0; act_data = '0; stat_clr = 1'b0;
        exp_hits = '0; exp_misses = '0;
        repeat (3) tick();
        chk("rst.valid", action_valid, 1'b0);
        chk("rst.hit", hit, 1'b0);
        chk("rst.addr", hit_addr, '0);
        chk("rst.action", action, '0);
        chk("rst.phv", pkt_hdr_vec_out, '0);
        chk("rst.hit_cnt", hit_cnt, '0);
        chk("rst.miss_cnt", miss_cnt, '0);
        chk("rst.key_ready", key_ready, 1'b1);
        aresetn = 1'b1;
        tick();

        // Key 0 held valid for 5 cycles: everything misses.
        extract_key = '0; pkt_hdr_vec = PHV_LEN'(32'h77); key_valid = 1'b1;
        tick(); tick();
        chk("lat.t2_valid", action_valid, 1'b0);
        tick();
        chk("lat.t3_valid", action_valid, 1'b1);
        chk("lat.t3_action", action, 25'h3f);
        chk("lat.t3_hit", hit, 1'b0);
        chk("lat.t3_addr", hit_addr, '0);
        chk("lat.t3_miss_cnt", miss_cnt, 32'd0);
        tick(); tick();
        chk("lat.t5_miss_cnt", miss_cnt, 32'd2);
        key_valid = 1'b0;
        repeat (4) tick();
        chk("lat.total_miss", miss_cnt, 32'd5);
        chk("lat.drained", action_valid, 1'b0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr.miss_cnt", miss_cnt, 32'd0);

        // Single exact entry.
        cfg_entry(4'd5, key_a, ones, 1'b1);
        act_write(4'd5, 25'h1234);
        lookup_check("e5.keyA", key_a, PHV_LEN'(32'hA1), 1'b1, 4'd5, 25'h1234);
        lookup_check("e5.keyB", key_b, PHV_LEN'(32'hB1), 1'b0, 4'd0, 25'h3f);

        // Wildcard at 2, exact at 1: lowest matching index wins.
        cfg_entry(4'd2, '0, '0, 1'b1);
        cfg_entry(4'd1, key_a, ones, 1'b1);
        act_write(4'd1, 25'h111);
        act_write(4'd2, 25'h222);
        lookup_check("prio.keyA", key_a, PHV_LEN'(32'hA2), 1'b1, 4'd1, 25'h111);
        lookup_check("prio.keyB", key_b, PHV_LEN'(32'hB2), 1'b1, 4'd2, 25'h222);

        // Eight back-to-back keys, downstream stalls in cycles 4..6.
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            action_ready = !(cyc >= 4 && cyc <= 6);
            if (sent < 8) begin
                key_valid = 1'b1;
                extract_key = (sent % 2 == 1) ? key_a : key_b;
                pkt_hdr_vec = PHV_LEN'(256 + sent);
            end else begin
                key_valid = 1'b0;
            end
            #1;
            if (action_valid) begin
                chk("stream.hit", hit, 1'b1);
                chk("stream.addr", hit_addr, (recv % 2 == 1) ? 4'd1 : 4'd2);
                chk("stream.action", action, (recv % 2 == 1) ? 25'h111 : 25'h222);
                chk("stream.phv", pkt_hdr_vec_out, PHV_LEN'(256 + recv));
                if (!action_ready) chk("stream.key_ready_stall", key_ready, 1'b0);
                else recv++;
            end
            if (key_valid && key_ready) sent++;
            tick();
        end
        key_valid = 1'b0; action_ready = 1'b1;
        chk("stream.recv", recv, 8);
        chk("stream.sent", sent, 8);
        tick(); tick();
        chk("stream.no_dup", action_valid, 1'b0);
        exp_hits = exp_hits + 32'd8;
        chk("stream.hit_cnt", hit_cnt, exp_hits);
        chk("stream.miss_cnt", miss_cnt, exp_misses);

        // Invalidate entry 5 while key A sits in S2.
        cfg_entry(4'd1, key_a, ones, 1'b0);
        cfg_entry(4'd2, '0, '0, 1'b0);
        extract_key = key_a; pkt_hdr_vec = PHV_LEN'(32'hC1); key_valid = 1'b1;
        tick();
        pkt_hdr_vec = PHV_LEN'(32'hC2);
        cfg_wr_en = 1'b1; cfg_addr = 4'd5; cfg_key = key_a; cfg_mask = ones; cfg_entry_valid = 1'b0;
        tick();
        key_valid = 1'b0; cfg_wr_en = 1'b0;
        tick();
        chk("inval.first_hit", hit, 1'b1);
        chk("inval.first_addr", hit_addr, 4'd5);
        chk("inval.first_action", action, 25'h1234);
        tick();
        chk("inval.second_valid", action_valid, 1'b1);
        chk("inval.second_hit", hit, 1'b0);
        chk("inval.second_action", action, 25'h3f);
        chk("inval.second_phv", pkt_hdr_vec_out, PHV_LEN'(32'hC2));
        tick();
        sat_bump(1'b1); sat_bump(1'b0);
        chk("inval.hit_cnt", hit_cnt, exp_hits);
        chk("inval.miss_cnt", miss_cnt, exp_misses);

        // Miss counter saturation.
        force dut.miss_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.miss_cnt;
        exp_misses = 32'hFFFF_FFFF;
        chk("sat.preload", miss_cnt, exp_misses);
        lookup_check("sat.miss", key_b, PHV_LEN'(32'hD1), 1'b0, 4'd0, 25'h3f);
        chk("sat.miss_cnt", miss_cnt, 32'hFFFF_FFFF);

        // Clear coincident with a hit handshake.
        cfg_entry(4'd5, key_a, ones, 1'b1);
        extract_key = key_a; pkt_hdr_vec = PHV_LEN'(32'hE1); key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick(); tick();
        chk("clrhit.hit", hit, 1'b1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clrhit.hit_cnt", hit_cnt, 32'd0);
        chk("clrhit.miss_cnt", miss_cnt, 32'd0);

        // Reset with a lookup in flight: no output emerges, entry valids cleared.
        extract_key = key_a; pkt_hdr_vec = PHV_LEN'(32'hF1); key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        chk("midrst.valid_a", action_valid, 1'b0);
        tick();
        chk("midrst.valid_b", action_valid, 1'b0);
        chk("midrst.hit_cnt", hit_cnt, 32'd0);
        exp_hits = '0; exp_misses = '0;
        lookup_check("midrst.keyA", key_a, PHV_LEN'(32'hF2), 1'b0, 4'd0, 25'h3f);
        chk("midrst.miss_cnt", miss_cnt, exp_misses);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
